// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the rv32i 5-stage core: load-use stall, taken-branch flush,
// data-memory wait freeze with timeout halt, and saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNTW     = 32
) (
  input  logic            clk,
  input  logic            r,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_br_taken,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_we,
  output logic            idex_flush,
  output logic            exmem_we,
  output logic            halted,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  // wcnt must be able to hold MAX_WAIT, the value it reaches on the halting edge.
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_HALT,
    SEL_FREEZE,
    SEL_BRANCH,
    SEL_LOADUSE,
    SEL_NORMAL
  } sel_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [CNTW-1:0] stall_q, stall_d;
  logic [CNTW-1:0] flush_q, flush_d;
  logic            freeze;
  logic            lu;
  logic            rs1_hit;
  logic            rs2_hit;
  sel_t            sel;

  assign freeze  = mem_req & ~mem_ready;
  assign rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);
  assign lu      = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

  // Reset is folded into the selector so the pipe is held flushed while r is high.
  always_comb begin
    sel = SEL_NORMAL;
    if (r)                     sel = SEL_RESET;
    else if (state_q == HALT)  sel = SEL_HALT;
    else if (freeze)           sel = SEL_FREEZE;
    else if (ex_br_taken)      sel = SEL_BRANCH;
    else if (lu)               sel = SEL_LOADUSE;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_we    = 1'b1;
    idex_flush = 1'b0;
    exmem_we   = 1'b1;
    unique case (sel)
      SEL_RESET: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_we    = 1'b0;
        exmem_we   = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      SEL_HALT, SEL_FREEZE: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
      end
      SEL_BRANCH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      SEL_LOADUSE: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q == RUN) begin
      if (freeze) begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WAIT_LAST) state_d = HALT;
      end else begin
        wcnt_d = '0;
      end
      // Counters stick at all-ones rather than wrapping.
      if ((sel == SEL_FREEZE || sel == SEL_LOADUSE) && stall_q != '1)
        stall_d = stall_q + 1'b1;
      if (sel == SEL_BRANCH && flush_q != '1)
        flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (r) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign halted    = (state_q == HALT);
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized
// stimulus against a rule-level reference model.
module tb_hazard_stall_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNTW     = 4;
  localparam int CMAX     = (1 << CNTW) - 1;

  // Output vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we}
  localparam logic [5:0] V_RESET = 6'b001010;
  localparam logic [5:0] V_HOLD  = 6'b000000;
  localparam logic [5:0] V_BR    = 6'b111111;
  localparam logic [5:0] V_LU    = 6'b000111;
  localparam logic [5:0] V_RUN   = 6'b110101;

  logic            clk = 1'b0;
  logic            r;
  logic [4:0]      id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, mem_req, mem_ready;
  logic            pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, halted;
  logic [CNTW-1:0] stall_cnt, flush_cnt;
  logic [5:0]      out_vec;

  int errors = 0;
  int checks = 0;

  // Reference model state, expressed as plain integers.
  bit m_halted;
  int m_wait_run, m_stalls, m_flushes;

  hazard_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNTW(CNTW)) dut (
    .clk(clk), .r(r),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_flush(idex_flush), .exmem_we(exmem_we), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;
  assign out_vec = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we};

  task automatic set_idle();
    r = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    r = 1'b1;
    @(posedge clk); #1;
    r = 1'b0;
    m_halted = 1'b0; m_wait_run = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic bit model_hazard();
    return ex_mem_read && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [5:0] model_vec();
    bit waiting = mem_req && !mem_ready;
    if (r)                 return V_RESET;
    if (m_halted)          return V_HOLD;
    if (waiting)           return V_HOLD;
    if (ex_br_taken)       return V_BR;
    if (model_hazard())    return V_LU;
    return V_RUN;
  endfunction

  function automatic void model_edge();
    bit waiting = mem_req && !mem_ready;
    if (r) begin
      m_halted = 1'b0; m_wait_run = 0; m_stalls = 0; m_flushes = 0;
    end else if (!m_halted) begin
      if (waiting) begin
        m_wait_run++;
        if (m_wait_run >= MAX_WAIT) m_halted = 1'b1;
        if (m_stalls < CMAX) m_stalls++;
      end else begin
        m_wait_run = 0;
        if (ex_br_taken) begin
          if (m_flushes < CMAX) m_flushes++;
        end else if (model_hazard()) begin
          if (m_stalls < CMAX) m_stalls++;
        end
      end
    end
  endfunction

  task automatic test_reset();
    set_idle();
    r = 1'b1; #1;
    checks++;
    if (out_vec !== V_RESET) begin errors++; $display("FAIL reset_outputs: got %b want %b", out_vec, V_RESET); end
    tick();
    checks++;
    if ({halted, stall_cnt, flush_cnt} !== '0) begin
      errors++; $display("FAIL reset_state: halted=%b stall=%0d flush=%0d want all 0", halted, stall_cnt, flush_cnt);
    end
    r = 1'b0; #1;
    checks++;
    if (out_vec !== V_RUN) begin errors++; $display("FAIL reset_release: got %b want %b", out_vec, V_RUN); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; #1;
    checks++;
    if (out_vec !== V_LU) begin errors++; $display("FAIL lu_rs1: got %b want %b", out_vec, V_LU); end
    tick();
    ex_mem_read = 1'b0; #1;
    checks++;
    if (out_vec !== V_RUN || stall_cnt !== 4'd1) begin
      errors++; $display("FAIL lu_clear: got %b stall=%0d want %b stall=1", out_vec, stall_cnt, V_RUN);
    end
    id_use_rs1 = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; #1;
    checks++;
    if (out_vec !== V_LU) begin errors++; $display("FAIL lu_rs2: got %b want %b", out_vec, V_LU); end
    tick();
    checks++;
    if (stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_rs2_count: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_no_stall();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; #1;
    checks++;
    if (out_vec !== V_RUN) begin errors++; $display("FAIL x0_no_stall: got %b want %b", out_vec, V_RUN); end
    tick();
    ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; #1;
    checks++;
    if (out_vec !== V_RUN) begin errors++; $display("FAIL unused_rs1: got %b want %b", out_vec, V_RUN); end
    tick();
    id_use_rs1 = 1'b1; ex_mem_read = 1'b0; #1;
    checks++;
    if (out_vec !== V_RUN) begin errors++; $display("FAIL not_load: got %b want %b", out_vec, V_RUN); end
    tick();
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("FAIL no_stall_count: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    ex_br_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1; #1;
    checks++;
    if (out_vec !== V_BR) begin errors++; $display("FAIL br_over_lu: got %b want %b", out_vec, V_BR); end
    tick();
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL br_counts: flush=%0d stall=%0d want 1,0", flush_cnt, stall_cnt);
    end
    mem_req = 1'b1; mem_ready = 1'b0; #1;
    checks++;
    if (out_vec !== V_HOLD) begin errors++; $display("FAIL freeze_over_br: got %b want %b", out_vec, V_HOLD); end
    tick();
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
      errors++; $display("FAIL freeze_br_counts: flush=%0d stall=%0d want 1,1", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_vec !== V_HOLD) begin errors++; $display("FAIL freeze_hold[%0d]: got %b want %b", i, out_vec, V_HOLD); end
      tick();
    end
    mem_ready = 1'b1; #1;
    checks++;
    if (out_vec !== V_RUN) begin errors++; $display("FAIL freeze_resume: got %b want %b", out_vec, V_RUN); end
    tick();
    mem_req = 1'b0; #1;
    checks++;
    if (out_vec !== V_RUN || stall_cnt !== 4'd3) begin
      errors++; $display("FAIL ready_no_req: got %b stall=%0d want %b stall=3", out_vec, stall_cnt, V_RUN);
    end
    // A fresh 3-cycle wait must not reach the 4-cycle timeout if the run count restarted.
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b1;
    tick();
    checks++;
    if (halted !== 1'b0 || stall_cnt !== 4'd6) begin
      errors++; $display("FAIL wait_restart: halted=%b stall=%0d want 0,6", halted, stall_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (MAX_WAIT - 1) tick();
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL timeout_early: halted=%b want 0", halted); end
    tick();
    checks++;
    if (halted !== 1'b1 || stall_cnt !== 4'(MAX_WAIT)) begin
      errors++; $display("FAIL timeout_halt: halted=%b stall=%0d want 1,%0d", halted, stall_cnt, MAX_WAIT);
    end
    mem_ready = 1'b1; ex_br_taken = 1'b1; #1;
    checks++;
    if (out_vec !== V_HOLD) begin errors++; $display("FAIL halt_hold: got %b want %b", out_vec, V_HOLD); end
    repeat (3) tick();
    checks++;
    if (halted !== 1'b1 || flush_cnt !== 4'd0 || stall_cnt !== 4'(MAX_WAIT)) begin
      errors++; $display("FAIL halt_sticky: halted=%b flush=%0d stall=%0d", halted, flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    r = 1'b1; #1;
    checks++;
    if (out_vec !== V_RESET) begin errors++; $display("FAIL mid_wait_reset_out: got %b want %b", out_vec, V_RESET); end
    tick();
    r = 1'b0; mem_req = 1'b0; #1;
    checks++;
    if (halted !== 1'b0 || stall_cnt !== 4'd0 || out_vec !== V_RUN) begin
      errors++; $display("FAIL mid_wait_cleared: halted=%b stall=%0d vec=%b", halted, stall_cnt, out_vec);
    end
    mem_req = 1'b1;
    repeat (MAX_WAIT - 1) tick();
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL mid_wait_count_restart: halted=%b want 0", halted); end
    tick();
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL mid_wait_then_halt: halted=%b want 1", halted); end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_br_taken = 1'b1;
    repeat (CMAX + 5) tick();
    checks++;
    if (flush_cnt !== 4'(CMAX)) begin errors++; $display("FAIL flush_sat: got %0d want %0d", flush_cnt, CMAX); end
    ex_br_taken = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    repeat (CMAX + 5) tick();
    checks++;
    if (stall_cnt !== 4'(CMAX)) begin errors++; $display("FAIL stall_sat: got %0d want %0d", stall_cnt, CMAX); end
  endtask

  task automatic test_random();
    logic [5:0] ev;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r           = ($urandom_range(0, 39) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 7) == 0);
      mem_req     = ($urandom_range(0, 2) == 0);
      mem_ready   = 1'($urandom_range(0, 1));
      #1;
      ev = model_vec();
      checks++;
      if (out_vec !== ev) begin errors++; $display("FAIL rand_out[%0d]: got %b want %b", i, out_vec, ev); end
      @(posedge clk);
      model_edge();
      #1;
      checks++;
      if (halted !== m_halted || stall_cnt !== 4'(m_stalls) || flush_cnt !== 4'(m_flushes)) begin
        errors++;
        $display("FAIL rand_state[%0d]: halted=%b stall=%0d flush=%0d want %b %0d %0d",
                 i, halted, stall_cnt, flush_cnt, m_halted, m_stalls, m_flushes);
      end
    end
  endtask

  initial begin
    set_idle();
    r = 1'b1;
    #2;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_freeze();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
